button_intr_ctrl: RTL and testbench

Downstream consumer of the debounced one-shot button pulse (DB_BTN). It turns each pulse into exactly one pending interrupt event and queues events in a saturating pending counter. It drives a level interrupt request to the multicycle MCU core and holds it until the core acknowledges. After each acknowledge it enforces a minimum request-low gap before re-asserting for the next queued event.

---
 rtl/intr_pkg.sv | 18 +
 rtl/pulse_rise_detect.sv | 30 +++
 rtl/button_intr_ctrl.sv | 129 ++++++++++++
 tb/tb_button_intr_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared definitions for interrupt request controllers.
// Holds the request FSM state encoding and the default sizing constants
// so that later interrupt sources can reuse the same structure.
package intr_pkg;

  // Default width of the pending-event counter (saturates at 2^W-1).
  localparam int unsigned PEND_W_DEF       = 4;
  // Default number of clocks the request stays low after an accepted ACK.
  localparam int unsigned HOLDOFF_CLKS_DEF = 8;

  // Request FSM states. Encoding 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } intr_state_t;

endpackage

// File: rtl/pulse_rise_detect.sv
// Single-cycle rising-edge detector.
// Ports:
//   CLK   in  system clock
//   RST_N in  asynchronous active-low reset
//   IN    in  level input to watch
//   RISE  out high for one clock when IN goes 0->1
// The history register resets to RST_VAL; with RST_VAL=1 an input that is
// already high when reset releases does not produce a rise.
module pulse_rise_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic IN,
  output logic RISE
);

  logic r_in_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_in_q <= RST_VAL;
    end else begin
      r_in_q <= IN;
    end
  end

  assign RISE = IN & ~r_in_q;

endmodule

// File: rtl/button_intr_ctrl.sv
// Button interrupt controller.
// Turns each debounced button pulse into one pending event, queues events in
// a saturating counter and drives a level interrupt request to the core until
// it is acknowledged, with a fixed low gap after each acknowledge.
// Ports:
//   CLK       in  system clock
//   RST_N     in  asynchronous active-low reset
//   DB_BTN    in  debounced button pulse (may be high several clocks)
//   INTR_EN   in  interrupt enable from the core
//   INTR_ACK  in  single-clock acknowledge from the core
//   OVF_CLR   in  clears the sticky overflow flag
//   INTR      out interrupt request level (registered, high only in ST_ASSERT)
//   PEND_CNT  out number of queued, unacknowledged events
//   OVF       out sticky flag: an event was lost to saturation
module button_intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned PEND_W       = PEND_W_DEF,
  parameter int unsigned HOLDOFF_CLKS = HOLDOFF_CLKS_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              DB_BTN,
  input  logic              INTR_EN,
  input  logic              INTR_ACK,
  input  logic              OVF_CLR,
  output logic              INTR,
  output logic [PEND_W-1:0] PEND_CNT,
  output logic              OVF
);

  localparam int unsigned     HO_W    = $clog2(HOLDOFF_CLKS + 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CLKS - 1);

  intr_state_t       r_state;
  intr_state_t       w_state_nxt;
  logic [PEND_W-1:0] r_pend;
  logic [HO_W-1:0]   r_ho;
  logic [HO_W-1:0]   w_ho_nxt;
  logic              r_ovf;

  logic w_rise;
  logic w_evt;
  logic w_acc;
  logic w_pend_max;
  logic w_pend_nz;

  pulse_rise_detect #(
    .RST_VAL(1'b1)
  ) u_rise (
    .CLK  (CLK),
    .RST_N(RST_N),
    .IN   (DB_BTN),
    .RISE (w_rise)
  );

  assign w_evt      = w_rise & INTR_EN;
  assign w_acc      = (r_state == ST_ASSERT) & INTR_ACK;
  assign w_pend_max = (r_pend == '1);
  assign w_pend_nz  = (r_pend != '0);

  // A simultaneous event and accept cancel out, so the counter only moves
  // when exactly one of them is present.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_evt & ~w_acc) begin
        if (!w_pend_max) begin
          r_pend <= r_pend + 1'b1;
        end
      end else if (w_acc & ~w_evt) begin
        r_pend <= r_pend - 1'b1;
      end

      // A new overflow wins over a same-clock clear.
      if (w_evt & ~w_acc & w_pend_max) begin
        r_ovf <= 1'b1;
      end else if (OVF_CLR) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ho_nxt    = r_ho;
    case (r_state)
      ST_IDLE: begin
        if (INTR_EN & w_pend_nz) begin
          w_state_nxt = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (INTR_ACK) begin
          w_state_nxt = ST_HOLDOFF;
          w_ho_nxt    = '0;
        end else if (!INTR_EN) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        w_ho_nxt = r_ho + 1'b1;
        if (r_ho == HO_LAST) begin
          w_state_nxt = (INTR_EN & w_pend_nz) ? ST_ASSERT : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_ho    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ho    <= w_ho_nxt;
    end
  end

  assign INTR     = (r_state == ST_ASSERT);
  assign PEND_CNT = r_pend;
  assign OVF      = r_ovf;

endmodule

// File: tb/tb_button_intr_ctrl.sv
module tb_button_intr_ctrl;

  localparam int PW   = 4;
  localparam int HO   = 8;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          db = 1'b0;
  logic          en = 1'b0;
  logic          ack = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          intr;
  logic [PW-1:0] pend_cnt;
  logic          ovf;

  int n_checks = 0;
  int n_errors = 0;

  button_intr_ctrl #(
    .PEND_W      (PW),
    .HOLDOFF_CLKS(HO)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .DB_BTN  (db),
    .INTR_EN (en),
    .INTR_ACK(ack),
    .OVF_CLR (ovf_clr),
    .INTR    (intr),
    .PEND_CNT(pend_cnt),
    .OVF     (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: a request line with a "low clocks still owed" counter.
  // After an accepted ack the line owes HO low clocks; once nothing is owed
  // it is high whenever enabled with work pending.
  int m_pend;
  bit m_ovf;
  bit m_intr;
  int m_owed;
  bit m_dbq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 0;
      m_ovf  <= 1'b0;
      m_intr <= 1'b0;
      m_owed <= 0;
      m_dbq  <= 1'b1;
    end else begin
      bit evt;
      bit accepted;
      bit lost;
      evt      = db && !m_dbq && en;
      accepted = m_intr && ack;
      lost     = evt && !accepted && (m_pend == PMAX);
      m_dbq    <= db;
      if (evt && !accepted && m_pend < PMAX) m_pend <= m_pend + 1;
      else if (accepted && !evt)             m_pend <= m_pend - 1;
      if (lost)         m_ovf <= 1'b1;
      else if (ovf_clr) m_ovf <= 1'b0;
      if (m_intr) begin
        m_intr <= en && !ack;
        m_owed <= ack ? HO : 0;
      end else if (m_owed > 1) begin
        m_owed <= m_owed - 1;
        m_intr <= 1'b0;
      end else begin
        m_owed <= 0;
        m_intr <= en && (m_pend != 0);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    n_checks++;
    if (intr !== m_intr) begin
      n_errors++;
      $display("FAIL model_intr t=%0t got %0b expected %0b", $time, intr, m_intr);
    end
    n_checks++;
    if (int'(pend_cnt) != m_pend || $isunknown(pend_cnt)) begin
      n_errors++;
      $display("FAIL model_pend t=%0t got %0d expected %0d", $time, pend_cnt, m_pend);
    end
    n_checks++;
    if (ovf !== m_ovf) begin
      n_errors++;
      $display("FAIL model_ovf t=%0t got %0b expected %0b", $time, ovf, m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    db = 1'b0; en = 1'b0; ack = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse(input int len);
    db = 1'b1;
    repeat (len) tick();
    db = 1'b0;
    tick();
  endtask

  // Issues an ack and returns how many clocks INTR then stays low (bounded).
  task automatic ack_and_count(output int lows);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    lows = 0;
    for (int j = 0; j < 3 * HO && !intr; j++) begin
      lows++;
      if (j < 3 * HO - 1) tick();
    end
  endtask

  initial begin
    int lows;
    #2;
    chk("reset_intr", int'(intr), 0);
    chk("reset_pend", int'(pend_cnt), 0);
    chk("reset_ovf", int'(ovf), 0);
    do_reset();

    // 1: latency and hold without ack
    en = 1'b1;
    db = 1'b1;
    tick();
    chk("t1_pend_after_k", int'(pend_cnt), 1);
    chk("t1_intr_after_k", int'(intr), 0);
    tick();
    chk("t1_intr_after_k1", int'(intr), 1);
    tick();
    db = 1'b0;
    repeat (18) tick();
    chk("t1_intr_held", int'(intr), 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t1_intr_after_ack", int'(intr), 0);
    chk("t1_pend_after_ack", int'(pend_cnt), 0);
    repeat (12) tick();

    // 2: three queued events, three acks with exact holdoff gaps
    for (int i = 0; i < 3; i++) begin
      db = 1'b1;
      repeat (2) tick();
      db = 1'b0;
      repeat (8) tick();
    end
    chk("t2_pend3", int'(pend_cnt), 3);
    chk("t2_intr_level", int'(intr), 1);
    for (int i = 0; i < 3; i++) begin
      ack_and_count(lows);
      chk("t2_pend_after_ack", int'(pend_cnt), 2 - i);
      if (i < 2) chk("t2_low_gap", lows, HO);
      else       chk("t2_stays_low", int'(intr), 0);
    end

    // 3: saturation and sticky overflow
    for (int i = 1; i <= 17; i++) begin
      pulse(2);
      tick();
      if (i == 15) begin
        chk("t3_pend15", int'(pend_cnt), 15);
        chk("t3_no_ovf_at15", int'(ovf), 0);
      end
      if (i == 16) chk("t3_ovf_at16", int'(ovf), 1);
    end
    chk("t3_pend_sat", int'(pend_cnt), 15);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_cleared", int'(ovf), 0);
    chk("t3_pend_kept", int'(pend_cnt), 15);
    db = 1'b1;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_set_wins", int'(ovf), 1);
    db = 1'b0;
    tick();
    do_reset();

    // 4: enable gating
    en = 1'b0;
    pulse(3);
    tick();
    chk("t4_disabled_pend", int'(pend_cnt), 0);
    chk("t4_disabled_intr", int'(intr), 0);
    en = 1'b1;
    db = 1'b1;
    tick();
    tick();
    db = 1'b0;
    chk("t4_intr_on", int'(intr), 1);
    en = 1'b0;
    tick();
    chk("t4_intr_drop", int'(intr), 0);
    chk("t4_pend_kept", int'(pend_cnt), 1);
    en = 1'b1;
    tick();
    chk("t4_intr_back", int'(intr), 1);

    // 5: event coincident with ack
    db = 1'b1;
    ack_and_count(lows);
    db = 1'b0;
    chk("t5_pend_same", int'(pend_cnt), 1);
    chk("t5_low_gap", lows, HO);
    chk("t5_reassert", int'(intr), 1);

    // 6: async reset mid-assert, release with button held
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_intr", int'(intr), 0);
    chk("t6_async_pend", int'(pend_cnt), 0);
    chk("t6_async_ovf", int'(ovf), 0);
    db = 1'b1;
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    repeat (3) tick();
    chk("t6_held_not_counted", int'(pend_cnt), 0);
    db = 1'b0;
    tick();
    pulse(3);
    chk("t6_next_counted", int'(pend_cnt), 1);

    // Randomized phase, checked every cycle by the model comparison.
    begin
      int db_left = 0;
      for (int c = 0; c < 4000; c++) begin
        if (db_left > 0) begin
          db = 1'b1;
          db_left--;
        end else begin
          db = 1'b0;
          if ($urandom_range(0, 5) == 0) db_left = int'($urandom_range(1, 5));
        end
        en      = ($urandom_range(0, 24) != 0);
        ack     = !ack && (intr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0));
        ovf_clr = ($urandom_range(0, 39) == 0);
        if (c == 2000) begin
          rst_n = 1'b0;
          #2;
          rst_n = 1'b1;
        end
        tick();
      end
      db = 1'b0; ack = 1'b0; ovf_clr = 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
